// File: rtl/seq_restoring_divider_pkg.sv
// Shared arithmetic-library definitions for the sequential restoring divider.
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of one carry-lookahead group in the subtractor.
  localparam int CLA_GROUP = 4;

  // Iteration counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_cla.sv
// Combinational W-bit a - b on a carry-lookahead adder: a + ~b + 1.
// Carries are looked ahead inside each 4-bit group and ripple between groups.
// cout = 1 means no borrow (a >= b).
module cla_subtractor
  import seq_restoring_divider_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         cout
);

  logic [W-1:0] bn;
  logic [W-1:0] g;
  logic [W-1:0] p;

  assign bn = ~b;
  assign g  = a & bn;
  assign p  = a ^ bn;

  // Per-bit carry as a flat generate/propagate product from its group's carry-in.
  always_comb begin : carry_chain
    logic [W:0] c;
    logic       acc;
    logic       pp;
    int         base;
    c    = '0;
    c[0] = 1'b1;
    acc  = 1'b0;
    pp   = 1'b0;
    base = 0;
    for (int i = 0; i < W; i++) begin
      base = (i / CLA_GROUP) * CLA_GROUP;
      acc  = g[i];
      pp   = p[i];
      for (int j = i - 1; j >= base; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & c[base]);
    end
    diff = p ^ c[W-1:0];
    cout = c[W];
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// start is only honoured in IDLE; results are held until the next accepted start.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   s;
  logic [WIDTH:0]   t;
  logic             no_borrow;
  logic [WIDTH:0]   r_it;
  logic [WIDTH-1:0] q_it;
  logic             div_zero_in;

  // One restoring step: shift in the next dividend bit, trial-subtract D.
  assign s = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  cla_subtractor #(.W(WIDTH + 1)) u_sub (
    .a    (s),
    .b    ({1'b0, d_q}),
    .diff (t),
    .cout (no_borrow)
  );

  assign r_it        = no_borrow ? t : s;
  assign q_it        = {q_q[WIDTH-2:0], no_borrow};
  assign div_zero_in = (divisor == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = div_zero_in ? DONE : RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

  // Datapath next values: load on accepted start, iterate in RUN, commit on the last step.
  always_comb begin
    cnt_d = cnt_q;
    r_d   = r_q;
    q_d   = q_q;
    d_d   = d_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (div_zero_in) begin
            quo_d = '1;
            rem_d = dividend;
            dbz_d = 1'b1;
          end else begin
            d_d   = divisor;
            q_d   = dividend;
            r_d   = '0;
            cnt_d = '0;
            dbz_d = 1'b0;
          end
        end
      end
      RUN: begin
        r_d   = r_it;
        q_d   = q_it;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          quo_d = q_it;
          rem_d = r_it[WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      r_q   <= r_d;
      q_q   <= q_d;
      d_q   <= d_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
